// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: oversampled ps2_clk/ps2_data in the clk domain, frame check,
// and a show-ahead byte FIFO popped through a ready/rd_en handshake.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   fall;
    logic                   data_s;

    logic [3:0]    bit_cnt;
    logic [9:0]    shift_reg;
    logic [TW-1:0] tmo_cnt;
    logic          frame_done;
    logic          frame_ok;
    logic          wr_req;

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          do_pop;
    logic          do_wr;
    logic [7:0]    mem [FIFO_DEPTH];

    // Synchronizers idle high so reset never manufactures a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            // NOTE: non-blocking assignments keep every stage sampling the previous value of its neighbour.
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign fall   = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
    assign data_s = data_sync[SYNC_STAGES-2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            tmo_cnt   <= '0;
        end else if (fall) begin
            tmo_cnt <= '0;
            if (bit_cnt == 4'd10) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt   <= bit_cnt + 4'd1;
                shift_reg <= {data_s, shift_reg[9:1]};
            end
        end else if (bit_cnt != 4'd0) begin
            // A stalled frame is abandoned quietly so the next start bit realigns.
            if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                bit_cnt <= '0;
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end else begin
            tmo_cnt <= '0;
        end
    end

    // shift_reg holds start in bit 0, data in 8:1, parity in 9; stop is still on the line.
    assign frame_done = fall && (bit_cnt == 4'd10);
    assign frame_ok   = ~shift_reg[0] & data_s & (^shift_reg[9:1]);
    assign wr_req     = frame_done & frame_ok;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop = rd_en & ~empty;
    assign do_wr  = wr_req & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= frame_done & ~frame_ok;
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_pop)
                overflow <= 1'b0;
            else if (wr_req && full)
                overflow <= 1'b1;
        end
    end

    // NOTE: storage has no reset; the output mux below hides stale contents while empty.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr[AW-1:0]] <= shift_reg[8:1];
    end

    assign ready = ~empty;
    assign data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: table-driven frames plus hand sequences for
// overflow, timeout and mid-frame reset, with a byte scoreboard queue.
module tb_ps2_rx_fifo;

    localparam int HALF    = 20;
    localparam int TIMEOUT = 300;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rd_en;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    int         total_checks = 0;
    int         pass_checks  = 0;
    int         err_cycles   = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovf;

    typedef struct {
        logic [7:0] d;
        logic       par_flip;
        logic       stop_bit;
        logic       exp_err;
    } vec_t;

    vec_t vecs[6];

    ps2_rx_fifo #(
        .FIFO_DEPTH    (8),
        .SYNC_STAGES   (3),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rd_en    (rd_en),
        .data     (data),
        .ready    (ready),
        .overflow (overflow),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1)
            err_cycles++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp)
            pass_checks++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip,
                              input logic stop_bit, input int nbits);
        logic [10:0] bits;
        bits = {stop_bit, (~^d) ^ par_flip, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_clk(HALF);
            ps2_clk = 1'b0;
            wait_clk(HALF);
            ps2_clk = 1'b1;
        end
        wait_clk(HALF);
        ps2_data = 1'b1;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        wait_clk(1);
        rd_en = 1'b0;
    endtask

    task automatic pop_check(input string name);
        logic [7:0] exp;
        exp = exp_q.pop_front();
        check(name, data, exp);
        pop();
    endtask

    task automatic send_model(input logic [7:0] d);
        send_frame(d, 1'b0, 1'b1, 11);
        wait_clk(10);
        if (exp_q.size() < 8)
            exp_q.push_back(d);
        else
            exp_ovf = 1'b1;
    endtask

    initial begin
        int e0;

        vecs[0] = '{d: 8'h1C, par_flip: 1'b0, stop_bit: 1'b1, exp_err: 1'b0};
        vecs[1] = '{d: 8'h1C, par_flip: 1'b1, stop_bit: 1'b1, exp_err: 1'b1};
        vecs[2] = '{d: 8'h1C, par_flip: 1'b0, stop_bit: 1'b0, exp_err: 1'b1};
        vecs[3] = '{d: 8'hF0, par_flip: 1'b0, stop_bit: 1'b1, exp_err: 1'b0};
        vecs[4] = '{d: 8'h1C, par_flip: 1'b0, stop_bit: 1'b1, exp_err: 1'b0};
        vecs[5] = '{d: 8'h00, par_flip: 1'b0, stop_bit: 1'b1, exp_err: 1'b0};

        rst      = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rd_en    = 1'b0;
        exp_ovf  = 1'b0;
        wait_clk(3);
        check("reset_data", data, 8'h00);
        check("reset_ready", ready, 1'b0);
        check("reset_overflow", overflow, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        rst = 1'b1;
        wait_clk(5);

        // Single frame, then a pop empties the FIFO.
        send_model(8'h1C);
        check("t1_ready", ready, 1'b1);
        check("t1_data", data, 8'h1C);
        check("t1_no_err", 32'(err_cycles), 32'd0);
        pop_check("t1_pop");
        check("t1_ready_after_pop", ready, 1'b0);
        check("t1_data_after_pop", data, 8'h00);

        // Table: each frame's error pulse width and the head byte afterwards.
        for (int i = 0; i < 6; i++) begin
            e0 = err_cycles;
            send_frame(vecs[i].d, vecs[i].par_flip, vecs[i].stop_bit, 11);
            wait_clk(10);
            if (!vecs[i].exp_err)
                exp_q.push_back(vecs[i].d);
            check($sformatf("vec%0d_err_cycles", i), 32'(err_cycles - e0), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_ready", i), ready, exp_q.size() != 0);
            check($sformatf("vec%0d_head", i), data, exp_q[0]);
        end
        while (exp_q.size() != 0)
            pop_check("drain_vec");
        check("drain_ready", ready, 1'b0);
        check("drain_data", data, 8'h00);

        // Pop while empty has no effect.
        pop();
        check("empty_pop_ready", ready, 1'b0);
        check("empty_pop_ovf", overflow, 1'b0);
        check("empty_pop_data", data, 8'h00);

        // Nine frames into an 8-deep FIFO.
        for (int k = 1; k <= 9; k++)
            send_model(8'(k));
        check("ovf_set", overflow, exp_ovf);
        check("ovf_head", data, 8'h01);
        check("ovf_ready", ready, 1'b1);
        pop_check("ovf_pop_first");
        check("ovf_cleared", overflow, 1'b0);
        while (exp_q.size() != 0)
            pop_check("ovf_drain");
        check("ovf_empty", ready, 1'b0);

        // Partial frame left idle beyond the timeout.
        e0 = err_cycles;
        send_frame(8'hAA, 1'b0, 1'b1, 5);
        wait_clk(2 * TIMEOUT);
        check("tmo_no_err", 32'(err_cycles - e0), 32'd0);
        check("tmo_no_write", ready, 1'b0);
        send_model(8'h5A);
        check("tmo_next_head", data, 8'h5A);
        check("tmo_next_err", 32'(err_cycles - e0), 32'd0);
        pop_check("tmo_pop");

        // Reset in the middle of a frame with bytes queued.
        send_model(8'h11);
        send_model(8'h22);
        send_model(8'h33);
        check("rstq_ready", ready, 1'b1);
        send_frame(8'h77, 1'b0, 1'b1, 6);
        rst = 1'b0;
        #1;
        check("rst_mid_data", data, 8'h00);
        check("rst_mid_ready", ready, 1'b0);
        check("rst_mid_ovf", overflow, 1'b0);
        check("rst_mid_err", frame_err, 1'b0);
        wait_clk(2);
        rst = 1'b1;
        exp_q.delete();
        wait_clk(3);
        send_model(8'h29);
        check("rst_next_head", data, 8'h29);
        pop_check("rst_next_pop");
        check("rst_next_empty", ready, 1'b0);

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
